// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift arbiter slice.
package shift_arb_pkg;

  localparam int unsigned SHIFT_W = 8;
  localparam int unsigned SHAMT_W = 3;

  typedef enum logic [1:0] {
    SRA = 2'b00,
    SRL = 2'b01,
    SLL = 2'b10,
    ROR = 2'b11
  } shift_op_t;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StFull = 1'b1
  } slot_state_e;

endpackage

// File: rtl/shift_unit_8.sv
// Combinational 8-bit barrel shifter: three conditional stages (1, 2, 4) with an op select.
module shift_unit_8
  import shift_arb_pkg::*;
(
  input  logic [SHIFT_W-1:0] a,
  input  logic [SHAMT_W-1:0] amt,
  input  shift_op_t          op,
  output logic [SHIFT_W-1:0] y
);

  logic [SHIFT_W-1:0] stage [SHAMT_W+1];

  assign stage[0] = a;

  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    localparam int unsigned N = 1 << g;
    logic [SHIFT_W-1:0] shifted;

    // SRA fill stays correct across stages because the MSB is preserved at every step.
    always_comb begin
      case (op)
        SRA:     shifted = {{N{stage[g][SHIFT_W-1]}}, stage[g][SHIFT_W-1:N]};
        SRL:     shifted = {{N{1'b0}}, stage[g][SHIFT_W-1:N]};
        SLL:     shifted = {stage[g][SHIFT_W-1-N:0], {N{1'b0}}};
        ROR:     shifted = {stage[g][N-1:0], stage[g][SHIFT_W-1:N]};
        default: shifted = stage[g];
      endcase
    end

    assign stage[g+1] = amt[g] ? shifted : stage[g];
  end

  assign y = stage[SHAMT_W];

endmodule

// File: rtl/shift_arbiter_8.sv
// Arbitrates NREQ requesters onto one shared shift unit with a single-entry response slot.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; default build is fixed priority.
module shift_arbiter_8
  import shift_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*8-1:0]    req_a,
  input  logic [NREQ*8-1:0]    req_b,
  input  logic [NREQ*2-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [SHIFT_W-1:0]   rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  slot_state_e        state_q, state_d;
  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     win_id;
  logic               slot_free;
  logic               accept;
  logic [SHIFT_W-1:0] shift_res;
  logic [SHIFT_W-1:0] rsp_data_q;
  logic [IDW-1:0]     rsp_id_q;

  logic [SHIFT_W-1:0] a_arr   [NREQ];
  logic [SHAMT_W-1:0] b_arr   [NREQ];
  shift_op_t          op_arr  [NREQ];
  logic [NREQ*5-1:0]  unused_b_hi;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g]               = req_a[8*g+7:8*g];
    assign b_arr[g]               = req_b[8*g+2:8*g];
    assign unused_b_hi[5*g+4:5*g] = req_b[8*g+7:8*g+3];
    assign op_arr[g]              = shift_op_t'(req_op[2*g+1:2*g]);
  end

  assign slot_free = (state_q == StIdle) || rsp_ready;

`ifdef SHIFT_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] rr_idx;

  // Search starts at the pointer; the first valid index met wins.
  always_comb begin
    grant  = '0;
    rr_idx = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      rr_idx = IDW'((32'(ptr_q) + off) % NREQ);
      if (req_valid[rr_idx] && (grant == '0)) begin
        grant[rr_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Isolate the lowest set bit: lowest index always wins.
  assign grant = req_valid & (~req_valid + NREQ'(1));
`endif

  always_comb begin
    win_id = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[IDW'(i)]) begin
        win_id = IDW'(i);
      end
    end
  end

  assign req_ready = grant & {NREQ{slot_free}};
  assign accept    = |(req_valid & req_ready);

  shift_unit_8 u_shift_unit (
    .a   (a_arr[win_id]),
    .amt (b_arr[win_id]),
    .op  (op_arr[win_id]),
    .y   (shift_res)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StFull;
      end
      StFull: begin
        if (accept)         state_d = StFull;
        else if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_data_q <= shift_res;
        rsp_id_q   <= win_id;
      end
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign busy      = rsp_valid;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter_8.sv
// Self-checking bench for shift_arbiter_8 (NREQ=2) with a reference arbiter/shifter scoreboard.
module tb_shift_arbiter_8;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [15:0]     req_a = '0;
  logic [15:0]     req_b = '0;
  logic [3:0]      req_op = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [7:0]      rsp_data;
  logic [IDW-1:0]  rsp_id;
  logic            busy;

  int checks = 0;
  int errors = 0;

  logic [8:0]      sb_q [$];
  logic            m_full = 1'b0;
  logic [IDW-1:0]  m_ptr  = '0;

  always #5 clk = ~clk;

  shift_arbiter_8 #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] a, input logic [2:0] k,
                                           input logic [1:0] op);
    logic [15:0] dbl;
    case (op)
      2'b00:   return 8'($signed(a) >>> k);
      2'b01:   return a >> k;
      2'b10:   return a << k;
      default: begin
        dbl = {a, a} >> k;
        return dbl[7:0];
      end
    endcase
  endfunction

  function automatic logic [7:0] sel8(input logic [15:0] v, input logic id);
    return id ? v[15:8] : v[7:0];
  endfunction

  function automatic logic [1:0] sel2(input logic [3:0] v, input logic id);
    return id ? v[3:2] : v[1:0];
  endfunction

  // Reference model: evaluated at each falling edge, predicts the next rising edge.
  task automatic monitor();
    logic [NREQ-1:0] eg;
    logic            found;
    logic [IDW-1:0]  ew;
    logic            sf;
    logic [8:0]      ent;
    eg    = '0;
    found = 1'b0;
    ew    = '0;
    sf    = !m_full || rsp_ready;
`ifdef SHIFT_ARB_RR_EN
    for (int off = 0; off < 2; off++) begin
      if (!found && req_valid[m_ptr ^ 1'(off)]) begin
        found = 1'b1;
        ew    = m_ptr ^ 1'(off);
      end
    end
`else
    if (req_valid[0]) begin
      found = 1'b1;
      ew    = 1'b0;
    end else if (req_valid[1]) begin
      found = 1'b1;
      ew    = 1'b1;
    end
`endif
    if (found && sf) eg[ew] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(eg));
    check("rsp_valid", 32'(rsp_valid), 32'(m_full));
    check("busy", 32'(busy), 32'(m_full));
    if (m_full && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(1), 32'(0));
      end else begin
        ent = sb_q.pop_front();
        check("sb_data", 32'(rsp_data), 32'(ent[7:0]));
        check("sb_id", 32'(rsp_id), 32'(ent[8]));
      end
    end
    if (found && sf) begin
      sb_q.push_back({ew, ref_shift(sel8(req_a, ew), sel8(req_b, ew)[2:0], sel2(req_op, ew))});
      m_full = 1'b1;
      m_ptr  = ~ew;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        sb_q.delete();
        m_full = 1'b0;
        m_ptr  = '0;
      end else begin
        monitor();
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op);
    if (id) begin
      req_a[15:8] = a;
      req_b[15:8] = b;
      req_op[3:2] = op;
    end else begin
      req_a[7:0]  = a;
      req_b[7:0]  = b;
      req_op[1:0] = op;
    end
    req_valid[id] = 1'b1;
  endtask

  // Returns at #1 after the accepting edge with the requester withdrawn.
  task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op);
    logic ok;
    ok = 1'b0;
    set_req(id, a, b, op);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("issue_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8] = '{
    '{1'b0, 8'h90, 8'h03, 2'b00, 8'hF2},
    '{1'b1, 8'h90, 8'hFB, 2'b01, 8'h12},
    '{1'b0, 8'h81, 8'h01, 2'b10, 8'h02},
    '{1'b1, 8'h81, 8'h01, 2'b11, 8'hC0},
    '{1'b0, 8'hA5, 8'h00, 2'b00, 8'hA5},
    '{1'b1, 8'hA5, 8'hF8, 2'b01, 8'hA5},
    '{1'b0, 8'hA5, 8'h00, 2'b10, 8'hA5},
    '{1'b1, 8'hA5, 8'h00, 2'b11, 8'hA5}
  };

  logic [IDW-1:0] cont_exp [4];
  logic           r1_seen;
  logic [7:0]     held_data;
  logic [IDW-1:0] held_id;

  initial begin
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(8'h00));
    check("rst_rsp_id", 32'(rsp_id), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed ops, amount masking and k=0
    foreach (vecs[i]) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      check("dir_valid", 32'(rsp_valid), 32'(1));
      check("dir_data", 32'(rsp_data), 32'(vecs[i].exp));
      check("dir_id", 32'(rsp_id), 32'(vecs[i].id));
    end
    @(posedge clk);
    #1;

    // Contention from a freshly reset pointer
    do_reset();
`ifdef SHIFT_ARB_RR_EN
    cont_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    cont_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    r1_seen = 1'b0;
    set_req(1'b0, 8'h40, 8'h01, 2'b01);
    set_req(1'b1, 8'h03, 8'h02, 2'b10);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      r1_seen = r1_seen | req_ready[1];
      @(posedge clk);
      #1;
      check("cont_valid", 32'(rsp_valid), 32'(1));
      check("cont_id", 32'(rsp_id), 32'(cont_exp[c]));
    end
`ifdef SHIFT_ARB_RR_EN
    check("cont_r1_granted", 32'(r1_seen), 32'(1));
`else
    check("cont_r1_never", 32'(r1_seen), 32'(0));
`endif
    req_valid = '0;
    @(posedge clk);
    #1;

    // Backpressure: slot held for 3 cycles while req1 waits
    rsp_ready = 1'b0;
    issue(1'b0, 8'h96, 8'h02, 2'b00);
    check("bp_data", 32'(rsp_data), 32'(8'hE5));
    held_data = rsp_data;
    held_id   = rsp_id;
    set_req(1'b1, 8'h0F, 8'h04, 2'b11);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready), 32'(0));
      check("bp_hold_data", 32'(rsp_data), 32'(held_data));
      check("bp_hold_id", 32'(rsp_id), 32'(held_id));
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(1'b1, 8'h0F, 8'h04, 2'b11);
    check("bp_next_data", 32'(rsp_data), 32'(8'hF0));
    check("bp_next_id", 32'(rsp_id), 32'(1));
    @(posedge clk);
    #1;

    // Asynchronous reset while a result is held
    rsp_ready = 1'b0;
    issue(1'b0, 8'h90, 8'h03, 2'b00);
    check("ar_pre_valid", 32'(rsp_valid), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(rsp_valid), 32'(0));
    check("ar_busy", 32'(busy), 32'(0));
    check("ar_data", 32'(rsp_data), 32'(8'h00));
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    set_req(1'b0, 8'h11, 8'h01, 2'b10);
    set_req(1'b1, 8'h22, 8'h01, 2'b10);
    @(posedge clk);
    #1;
    check("ar_first_winner", 32'(rsp_id), 32'(0));
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("sb_left", 32'(sb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
